// File: rtl/pll_phase_ctrl_if.sv
// Request/status bundle between a phase-tuning initiator and pll_phase_ctrl.
// master = requester, slave = the phase controller.
interface pll_phase_ctrl_if #(
  parameter int STEP_W = 8,
  parameter int POS_W  = 6
);
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_sel;
  logic                 req_dir;
  logic [STEP_W-1:0]    req_steps;
  logic                 req_load;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [4*POS_W-1:0]   phase_pos;

  modport master (
    output req_valid, req_sel, req_dir, req_steps, req_load,
    input  req_ready, busy, done, err, phase_pos
  );

  modport slave (
    input  req_valid, req_sel, req_dir, req_steps, req_load,
    output req_ready, busy, done, err, phase_pos
  );
endinterface

// File: rtl/pll_phase_ctrl.sv
// Dynamic phase-shift initiator for the ECP5 EHXPLLL: sequences PHASESTEP/PHASELOADREG
// pulses for "shift output N by K steps" requests and tracks each output's phase position.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a request; ready when the PLL is locked
// SETUP   | PHASESEL/PHASEDIR settling before the first pulse
// STEP_LO | PHASESTEP driven low
// STEP_HI | PHASESTEP released, gap before next action
// LOAD_LO | PHASELOADREG driven low
// LOAD_HI | PHASELOADREG released, gap before finishing
module pll_phase_ctrl #(
  parameter int SETUP_CYC = 4,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 4,
  parameter int STEP_W    = 8,
  parameter int PHASE_MOD = 48,
  parameter int POS_W     = 6
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            pll_locked,
  pll_phase_ctrl_if.slave req,
  output logic [1:0]      pll_phasesel,
  output logic            pll_phasedir,
  output logic            pll_phasestep,
  output logic            pll_phaseloadreg
);

  localparam int CMAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int CMAX    = (CMAX_SP > GAP_CYC) ? CMAX_SP : GAP_CYC;
  localparam int CNT_W   = $clog2(CMAX + 1);
  localparam logic [POS_W-1:0] POS_TOP = POS_W'(PHASE_MOD - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, STEP_LO, STEP_HI, LOAD_LO, LOAD_HI
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [STEP_W-1:0] rem, rem_nxt;
  logic [1:0]        sel_q;
  logic              dir_q;
  logic              load_q;
  logic              lock_meta, locked_s;
  logic              accept, step_ev, done_nxt, err_nxt;
  logic              done_q, err_q;
  logic [POS_W-1:0]  pos_q [4];

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rem_nxt   = rem;
    accept    = 1'b0;
    step_ev   = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    if (state != IDLE && !locked_s) begin
      state_nxt = IDLE;
      err_nxt   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req.req_valid && locked_s) begin
            accept    = 1'b1;
            state_nxt = SETUP;
            // one extra SETUP cycle: the pins take the new values on the first SETUP edge
            cnt_nxt   = CNT_W'(SETUP_CYC);
            rem_nxt   = req.req_steps;
          end
        end
        SETUP, STEP_HI: begin
          if (cnt == '0) begin
            if (rem != '0) begin
              state_nxt = STEP_LO;
              cnt_nxt   = CNT_W'(PULSE_CYC - 1);
            end else if (load_q) begin
              state_nxt = LOAD_LO;
              cnt_nxt   = CNT_W'(PULSE_CYC - 1);
            end else begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        STEP_LO: begin
          if (cnt == '0) begin
            step_ev   = 1'b1;
            rem_nxt   = rem - STEP_W'(1);
            state_nxt = STEP_HI;
            cnt_nxt   = CNT_W'(GAP_CYC - 1);
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        LOAD_LO: begin
          if (cnt == '0) begin
            state_nxt = LOAD_HI;
            cnt_nxt   = CNT_W'(GAP_CYC - 1);
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        LOAD_HI: begin
          if (cnt == '0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt              <= '0;
      rem              <= '0;
      sel_q            <= '0;
      dir_q            <= 1'b1;
      load_q           <= 1'b0;
      lock_meta        <= 1'b0;
      locked_s         <= 1'b0;
      pll_phasesel     <= '0;
      pll_phasedir     <= 1'b1;
      pll_phasestep    <= 1'b1;
      pll_phaseloadreg <= 1'b1;
      done_q           <= 1'b0;
      err_q            <= 1'b0;
      for (int n = 0; n < 4; n++) pos_q[n] <= '0;
    end else begin
      lock_meta        <= pll_locked;
      locked_s         <= lock_meta;
      cnt              <= cnt_nxt;
      rem              <= rem_nxt;
      done_q           <= done_nxt;
      err_q            <= err_nxt;
      // pulse pins are registered so the PLL never sees state-decode glitches
      pll_phasestep    <= (state_nxt != STEP_LO);
      pll_phaseloadreg <= (state_nxt != LOAD_LO);
      if (accept) begin
        sel_q  <= req.req_sel;
        dir_q  <= req.req_dir;
        load_q <= req.req_load;
      end
      if (state == SETUP) begin
        pll_phasesel <= sel_q;
        pll_phasedir <= dir_q;
      end
      // lock loss: the PLL relocks at its static phase, so all positions restart at 0
      if (err_nxt) begin
        for (int n = 0; n < 4; n++) pos_q[n] <= '0;
      end else if (step_ev) begin
        if (dir_q)
          pos_q[sel_q] <= (pos_q[sel_q] == '0) ? POS_TOP : pos_q[sel_q] - POS_W'(1);
        else
          pos_q[sel_q] <= (pos_q[sel_q] == POS_TOP) ? '0 : pos_q[sel_q] + POS_W'(1);
      end
    end
  end

  always_comb begin
    req.phase_pos = '0;
    for (int n = 0; n < 4; n++) req.phase_pos[n*POS_W +: POS_W] = pos_q[n];
  end

  assign req.req_ready = (state == IDLE) && locked_s;
  assign req.busy      = (state != IDLE);
  assign req.done      = done_q;
  assign req.err       = err_q;

endmodule
